// File: rtl/uart_rx_fifo_mapper.sv
// uart_rx_fifo_mapper: memory-mapped UART receive FIFO for the 6502 bus.
// Registers: 0 DATA, 1 STATUS, 2 COUNT, 3 CTRL. The level IRQ asserts when occupancy
// reaches IRQ_THRESH and CTRL.irq_en is set.
// Optional feature macro: UART_RX_FIFO_AUTOPOP_EN (a DATA read also pops the head).
module uart_rx_fifo_mapper #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned IRQ_THRESH = 1,
  parameter bit          IRQ_EN_RST = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] uart_byte,
  input  logic       uart_byte_ready,
  input  logic       sel,
  input  logic [1:0] reg_addr,
  input  logic       we,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       irq
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DepthC  = CW'(DEPTH);
  localparam logic [CW-1:0] ThreshC = CW'(IRQ_THRESH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          irq_en_q, irq_en_d;
  logic          irq_q, irq_d;
  logic [7:0]    rdata_q, rdata_d;

  logic empty, full;
  logic data_wr, data_rd, ctrl_wr;
  logic pop_req, pop, push, flush, clr_ovf, ovf_set;
  logic [8:0] count_ext;
  logic [7:0] count_sat;

  assign empty   = (count_q == '0);
  assign full    = (count_q == DepthC);
  assign data_wr = sel && we && (reg_addr == 2'd0);
  assign data_rd = sel && !we && (reg_addr == 2'd0);
  assign ctrl_wr = sel && we && (reg_addr == 2'd3);
  assign flush   = ctrl_wr && wdata[2];
  assign clr_ovf = ctrl_wr && wdata[1];

`ifdef UART_RX_FIFO_AUTOPOP_EN
  assign pop_req = data_wr || data_rd;
`else
  assign pop_req = data_wr;
`endif

  // A pop on an empty FIFO is ignored; a same-cycle pop frees the slot for a push when full.
  assign pop     = pop_req && !empty;
  assign push    = uart_byte_ready && (!full || pop) && !flush;
  assign ovf_set = uart_byte_ready && full && !pop && !flush;

  assign count_ext = 9'(count_q);
  assign count_sat = count_ext[8] ? 8'hFF : count_ext[7:0];

  // Next-state for pointers, count, sticky flags, IRQ and the read-data latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    irq_en_d = irq_en_q;
    rdata_d  = rdata_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end

    // Set wins over a same-cycle clear.
    if (clr_ovf) ovf_d = 1'b0;
    if (ovf_set) ovf_d = 1'b1;

    if (ctrl_wr) irq_en_d = wdata[0];
    irq_d = irq_en_d && (count_d >= ThreshC);

    // Reads see the state before this edge's updates.
    if (sel && !we) begin
      unique case (reg_addr)
        2'd0:    rdata_d = empty ? 8'h00 : mem_q[rd_ptr_q];
        2'd1:    rdata_d = {4'h0, irq_q, ovf_q, full, !empty};
        2'd2:    rdata_d = count_sat;
        default: rdata_d = {7'h00, irq_en_q};
      endcase
    end
  end

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= uart_byte;
  end

  // Control state with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      irq_en_q <= IRQ_EN_RST;
      irq_q    <= 1'b0;
      rdata_q  <= 8'h00;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
      rdata_q  <= rdata_d;
    end
  end

  assign rdata = rdata_q;
  assign irq   = irq_q;

endmodule
